// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   addr_w()             : address width for a register count (clog2, min 1)
//   slice_lo()           : LSB offset of field k in a packed port of w-bit fields
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for the register file.
//   clk, rst            : clock, synchronous active-high reset
//   iss_valid, iss_addr : mark iss_addr pending
//   we0/wa0, we1/wa1    : write ports; a write clears the target's bit
//   pend                : registered pending vector
//   any_pending         : OR of pend
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    output logic [NREGS-1:0] pend,
    output logic             any_pending
);

    logic [NREGS-1:0] set_v;
    logic [NREGS-1:0] clr_v;
    logic [NREGS-1:0] pend_nxt;

    always_comb begin
        set_v = iss_valid ? (NREGS'(1) << iss_addr) : '0;
        clr_v = '0;
        if (we0) clr_v = clr_v | (NREGS'(1) << wa0);
        if (we1) clr_v = clr_v | (NREGS'(1) << wa1);
        // A new issue outranks a write to the same register: the write is the
        // old producer's result, the issue names a newer one still in flight.
        pend_nxt = (pend & ~clr_v) | set_v;
        if (ZERO_REG) pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    assign any_pending = |pend;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with pending scoreboard.
//   clk, rst     : clock, synchronous active-high reset (clears regs and pending)
//   rd_addr      : NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data      : NRD packed read data, combinational, optional write bypass
//   rd_pending   : pending bit of each read address (registered state only)
//   we0/wa0/wd0  : write port 0 (ALU)
//   we1/wa1/wd1  : write port 1 (load/writeback), wins over port 0
//   iss_valid/iss_addr : mark destination register pending
//   dbg_addr/dbg_data  : stored contents, never bypassed
//   any_pending  : OR of all pending bits
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_pending,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [XLEN-1:0]   wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic [AW-1:0]     dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic              any_pending
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic             wr0_ok;
    logic             wr1_ok;

    assign wr0_ok = we0 && !(ZERO_REG && (wa0 == '0));
    assign wr1_ok = we1 && !(ZERO_REG && (wa1 == '0));

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr0_ok) regs[wa0] <= wd0;
            if (wr1_ok) regs[wa1] <= wd1;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .we0         (we0),
        .wa0         (wa0),
        .we1         (we1),
        .wa1         (wa1),
        .pend        (pend),
        .any_pending (any_pending)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;

        assign a = rd_addr[slice_lo(k, AW) +: AW];

        always_comb begin
            v = regs[a];
            if (BYPASS) begin
                if (we1 && (wa1 == a))      v = wd1;
                else if (we0 && (wa0 == a)) v = wd0;
            end
            if (ZERO_REG && (a == '0)) v = '0;
        end

        assign rd_data[slice_lo(k, XLEN) +: XLEN] = v;
        // Pending reflects registered state only; a same-cycle write does not
        // clear it early, costing at most one extra stall.
        assign rd_pending[k] = pend[a];
    end

    assign dbg_data = (ZERO_REG && (dbg_addr == '0)) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 4;
    localparam int NV   = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic              we0, we1, iss_valid;
    logic [AW-1:0]     wa0, wa1, iss_addr, dbg_addr;
    logic [XLEN-1:0]   wd0, wd1;

    logic [NRD*XLEN-1:0] rd_data_b,    rd_data_n;
    logic [NRD-1:0]      rd_pending_b, rd_pending_n;
    logic [XLEN-1:0]     dbg_data_b,   dbg_data_n;
    logic                any_b,        any_n;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pending_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data_b), .any_pending(any_b)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(NRD), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(rd_pending_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data_n), .any_pending(any_n)
    );

    typedef struct {
        logic            rst;
        logic            we0;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic            we1;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic            iv;
        logic [AW-1:0]   ia;
        logic [AW-1:0]   ra [NRD];
        logic [AW-1:0]   dbg;
        logic [XLEN-1:0] erd [NRD];
        logic [NRD-1:0]  ep;
        logic [XLEN-1:0] edbg;
        logic            eany;
        logic [XLEN-1:0] enb0;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(
        input int r, input int w0, input int a0, input logic [31:0] d0,
        input int w1, input int a1, input logic [31:0] d1,
        input int iv, input int ia,
        input int r0, input int r1, input int r2, input int r3, input int dbg,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
        input logic [3:0] ep, input logic [31:0] edbg, input int eany, input logic [31:0] enb0);
        vec_t v;
        v.rst = r[0];   v.we0 = w0[0]; v.wa0 = 5'(a0); v.wd0 = d0;
        v.we1 = w1[0];  v.wa1 = 5'(a1); v.wd1 = d1;
        v.iv  = iv[0];  v.ia  = 5'(ia);
        v.ra[0] = 5'(r0); v.ra[1] = 5'(r1); v.ra[2] = 5'(r2); v.ra[3] = 5'(r3);
        v.dbg = 5'(dbg);
        v.erd[0] = e0; v.erd[1] = e1; v.erd[2] = e2; v.erd[3] = e3;
        v.ep = ep; v.edbg = edbg; v.eany = eany[0]; v.enb0 = enb0;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        iss_valid = v.iv; iss_addr = v.ia; dbg_addr = v.dbg;
        rd_addr = {v.ra[3], v.ra[2], v.ra[1], v.ra[0]};
    endtask

    task automatic idle(input int ra0);
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0; dbg_addr = '0;
        rd_addr = {5'd0, 5'd0, 5'd0, 5'(ra0)};
    endtask

    initial begin
        //              rst we0 wa0 wd0           we1 wa1 wd1           iv ia  r0 r1 r2 r3 dbg  e0            e1            e2            e3          ep       edbg          any enb0
        vecs[0]  = mk(0, 1, 5, 32'h55,        1, 6, 32'h66,        0, 0,  5, 6, 0, 1, 5,  32'h55,       32'h66,       0,            0,          4'b0000, 0,            0, 0);
        vecs[1]  = mk(1, 1, 5, 32'hDEAD,      0, 0, 0,             1, 4,  6, 7, 0, 1, 5,  32'h66,       0,            0,            0,          4'b0000, 32'h55,       0, 32'h66);
        vecs[2]  = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  5, 6, 0, 4, 5,  0,            0,            0,            0,          4'b0000, 0,            0, 0);
        vecs[3]  = mk(0, 1, 3, 32'h12345678,  1, 0, 32'hFFFFFFFF,  0, 0,  3, 0, 3, 2, 3,  32'h12345678, 0,            32'h12345678, 0,          4'b0000, 0,            0, 0);
        vecs[4]  = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  3, 0, 3, 0, 0,  32'h12345678, 0,            32'h12345678, 0,          4'b0000, 0,            0, 32'h12345678);
        vecs[5]  = mk(0, 1, 7, 32'h77777777,  0, 0, 0,             0, 0,  7, 7, 7, 7, 7,  32'h77777777, 32'h77777777, 32'h77777777, 32'h77777777, 4'b0000, 0,          0, 0);
        vecs[6]  = mk(0, 1, 7, 32'hAAAA0000,  1, 7, 32'h0000BBBB,  0, 0,  7, 7, 3, 0, 7,  32'h0000BBBB, 32'h0000BBBB, 32'h12345678, 0,          4'b0000, 32'h77777777, 0, 32'h77777777);
        vecs[7]  = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  7, 3, 7, 0, 7,  32'h0000BBBB, 32'h12345678, 32'h0000BBBB, 0,          4'b0000, 32'h0000BBBB, 0, 32'h0000BBBB);
        vecs[8]  = mk(0, 0, 0, 0,             0, 0, 0,             1, 9,  9, 7, 9, 0, 9,  0,            32'h0000BBBB, 0,            0,          4'b0000, 0,            0, 0);
        vecs[9]  = mk(0, 0, 0, 0,             1, 9, 32'h99,        0, 0,  9, 9, 1, 0, 9,  32'h99,       32'h99,       0,            0,          4'b0011, 0,            1, 0);
        vecs[10] = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  9, 9, 1, 0, 9,  32'h99,       32'h99,       0,            0,          4'b0000, 32'h99,       0, 32'h99);
        vecs[11] = mk(0, 1, 9, 32'h1234,      0, 0, 0,             1, 9,  9, 2, 2, 2, 9,  32'h1234,     0,            0,            0,          4'b0000, 32'h99,       0, 32'h99);
        vecs[12] = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  9, 1, 1, 1, 9,  32'h1234,     0,            0,            0,          4'b0001, 32'h1234,     1, 32'h1234);
        vecs[13] = mk(0, 1, 1, 11,            1, 2, 12,            0, 0,  1, 2, 1, 0, 2,  11,           12,           11,           0,          4'b0000, 0,            1, 0);
        vecs[14] = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  1, 2, 1, 0, 2,  11,           12,           11,           0,          4'b0000, 12,           1, 11);
        vecs[15] = mk(0, 0, 0, 0,             1, 2, 32'h22,        0, 0,  2, 1, 2, 9, 2,  32'h22,       11,           32'h22,       32'h1234,   4'b1000, 12,           1, 12);
        vecs[16] = mk(0, 1, 5, 32'h5,         0, 0, 0,             1, 4,  4, 6, 2, 9, 2,  0,            0,            32'h22,       32'h1234,   4'b1000, 32'h22,       1, 0);
        vecs[17] = mk(0, 0, 0, 0,             1, 3, 32'h33,        1, 6,  4, 6, 5, 9, 5,  0,            0,            32'h5,        32'h1234,   4'b1001, 32'h5,        1, 0);
        vecs[18] = mk(1, 1, 8, 32'h88,        0, 0, 0,             1, 10, 4, 6, 3, 9, 3,  0,            0,            32'h33,       32'h1234,   4'b1011, 32'h33,       1, 0);
        vecs[19] = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  4, 6, 3, 9, 8,  0,            0,            0,            0,          4'b0000, 0,            0, 0);
        vecs[20] = mk(0, 1, 4, 32'h44,        0, 0, 0,             1, 12, 4, 12, 8, 10, 4, 32'h44,      0,            0,            0,          4'b0000, 0,            0, 0);
        vecs[21] = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  4, 12, 8, 10, 4, 32'h44,      0,            0,            0,          4'b0010, 32'h44,       1, 32'h44);
        vecs[22] = mk(0, 0, 0, 0,             1, 12, 32'hC,        1, 0,  0, 12, 0, 0, 12, 0,           32'hC,        0,            0,          4'b0010, 0,            1, 0);
        vecs[23] = mk(0, 0, 0, 0,             0, 0, 0,             0, 0,  0, 12, 0, 0, 12, 0,           32'hC,        0,            0,          4'b0000, 32'hC,        0, 0);

        idle(0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            for (int k = 0; k < NRD; k++)
                check($sformatf("rd_data%0d", k), i, rd_data_b[k*XLEN +: XLEN], vecs[i].erd[k]);
            check("rd_pending", i, {28'd0, rd_pending_b}, {28'd0, vecs[i].ep});
            check("dbg_data",   i, dbg_data_b, vecs[i].edbg);
            check("any_pending", i, {31'd0, any_b}, {31'd0, vecs[i].eany});
            check("nobypass_rd0", i, rd_data_n[XLEN-1:0], vecs[i].enb0);
        end

        // A pending bit survives several idle cycles and clears only after
        // the write edge, not during the writing cycle.
        @(negedge clk);
        idle(20);
        iss_valid = 1'b1; iss_addr = 5'd20;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle(20);
            #2;
            check("hold_pending", 100 + c, {31'd0, rd_pending_b[0]}, 32'd1);
            check("hold_any",     100 + c, {31'd0, any_b}, 32'd1);
        end
        @(negedge clk);
        idle(20);
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hCAFE0020;
        #2;
        check("wr_cycle_pending", 103, {31'd0, rd_pending_b[0]}, 32'd1);
        check("wr_cycle_bypass",  103, rd_data_b[XLEN-1:0], 32'hCAFE0020);
        @(negedge clk);
        idle(20);
        dbg_addr = 5'd20;
        #2;
        check("post_wr_pending", 104, {31'd0, rd_pending_b[0]}, 32'd0);
        check("post_wr_any",     104, {31'd0, any_b}, 32'd0);
        check("post_wr_dbg",     104, dbg_data_b, 32'hCAFE0020);
        check("post_wr_nb",      104, rd_data_n[XLEN-1:0], 32'hCAFE0020);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
